pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/redirect controller: front-end fetch tracking (FETCH/FKILL),
// back-end stall, load-use interlock and branch redirect, plus event counters.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp_i,
    input  logic        dmem_req_i,
    input  logic        dmem_resp_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    output logic        imem_read_o,
    output logic        pc_load_o,
    output logic        pc_sel_o,
    output logic [31:0] pc_target_o,
    output logic        if_id_load_o,
    output logic        if_id_flush_o,
    output logic        id_ex_load_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_load_o,
    output logic        mem_wb_load_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic {
        FETCH = 1'b0,
        FKILL = 1'b1
    } fe_state_t;

    fe_state_t   state, state_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic        redirect_acc;
    logic        back_stall;
    logic        load_use;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign back_stall  = dmem_req_i & ~dmem_resp_i;
    assign load_use    = ex_memread_i & (ex_rd_i != 5'd0) &
                         ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    assign imem_read_o = ~rst;
    assign pc_target_o = (state == FKILL) ? pend_target : redirect_target_i;

    always_comb begin
        pc_load_o       = 1'b0;
        pc_sel_o        = 1'b0;
        if_id_load_o    = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_load_o    = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_load_o   = 1'b0;
        mem_wb_load_o   = 1'b0;
        state_nxt       = state;
        pend_target_nxt = pend_target;
        redirect_acc    = 1'b0;

        if (rst) begin
            state_nxt = FETCH;
        end else if (back_stall) begin
            // Whole pipe frozen; a redirect in EX simply reasserts next cycle.
            state_nxt = state;
        end else if (state == FKILL) begin
            // Wrong-path fetch still outstanding: discard it when it returns.
            if_id_flush_o = 1'b1;
            id_ex_load_o  = 1'b1;
            ex_mem_load_o = 1'b1;
            mem_wb_load_o = 1'b1;
            if (ex_redirect_i) begin
                pend_target_nxt = redirect_target_i;
                redirect_acc    = 1'b1;
            end
            if (imem_resp_i) begin
                pc_load_o = 1'b1;
                pc_sel_o  = 1'b1;
                state_nxt = FETCH;
            end
        end else if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            ex_mem_load_o = 1'b1;
            mem_wb_load_o = 1'b1;
            redirect_acc  = 1'b1;
            if (imem_resp_i) begin
                pc_load_o = 1'b1;
                pc_sel_o  = 1'b1;
            end else begin
                pend_target_nxt = redirect_target_i;
                state_nxt       = FKILL;
            end
        end else if (load_use) begin
            id_ex_flush_o = 1'b1;
            ex_mem_load_o = 1'b1;
            mem_wb_load_o = 1'b1;
        end else if (!imem_resp_i) begin
            if_id_flush_o = 1'b1;
            id_ex_load_o  = 1'b1;
            ex_mem_load_o = 1'b1;
            mem_wb_load_o = 1'b1;
        end else begin
            pc_load_o     = 1'b1;
            if_id_load_o  = 1'b1;
            id_ex_load_o  = 1'b1;
            ex_mem_load_o = 1'b1;
            mem_wb_load_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pend_target <= 32'd0;
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 16'd0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
            if (!pc_load_o)
                stall_cnt_o <= sat_inc32(stall_cnt_o);
            if (redirect_acc)
                flush_cnt_o <= sat_inc16(flush_cnt_o);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural reference model queues the
// expected outputs for each driven cycle; they are popped and compared per cycle.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_resp_i, dmem_req_i, dmem_resp_i, ex_redirect_i, ex_memread_i;
    logic [31:0] redirect_target_i;
    logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
    logic        imem_read_o, pc_load_o, pc_sel_o;
    logic [31:0] pc_target_o;
    logic        if_id_load_o, if_id_flush_o, id_ex_load_o, id_ex_flush_o;
    logic        ex_mem_load_o, mem_wb_load_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_resp_i(imem_resp_i), .dmem_req_i(dmem_req_i), .dmem_resp_i(dmem_resp_i),
        .ex_redirect_i(ex_redirect_i), .redirect_target_i(redirect_target_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .imem_read_o(imem_read_o), .pc_load_o(pc_load_o), .pc_sel_o(pc_sel_o),
        .pc_target_o(pc_target_o),
        .if_id_load_o(if_id_load_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_load_o(id_ex_load_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mem_load_o(ex_mem_load_o), .mem_wb_load_o(mem_wb_load_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] tgt;
        logic [31:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    bit          m_fkill = 1'b0;
    logic [31:0] m_pend  = 32'd0;
    logic [31:0] m_sc    = 32'd0;
    logic [15:0] m_fc    = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ctrl bit order: imem_read pc_load pc_sel if_id_load if_id_flush id_ex_load id_ex_flush ex_mem_load mem_wb_load
    task automatic model_eval(output logic [8:0] c, output bit nk, output logic [31:0] np,
                              output bit acc);
        bit bs, lu;
        bs  = dmem_req_i & ~dmem_resp_i;
        lu  = ex_memread_i && (ex_rd_i != 0) && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
        nk  = m_fkill;
        np  = m_pend;
        acc = 1'b0;
        if (rst) begin
            c = 9'b0_0000_0000;
        end else if (bs) begin
            c = 9'b1_0000_0000;
        end else if (m_fkill) begin
            c = 9'b1_0001_1011;
            if (ex_redirect_i) begin np = redirect_target_i; acc = 1'b1; end
            if (imem_resp_i) begin c[7] = 1'b1; c[6] = 1'b1; nk = 1'b0; end
        end else if (ex_redirect_i) begin
            c   = 9'b1_0001_0111;
            acc = 1'b1;
            if (imem_resp_i) begin c[7] = 1'b1; c[6] = 1'b1; end
            else begin nk = 1'b1; np = redirect_target_i; end
        end else if (lu) begin
            c = 9'b1_0000_0111;
        end else if (!imem_resp_i) begin
            c = 9'b1_0001_1011;
        end else begin
            c = 9'b1_1010_1011;
        end
    endtask

    // Inputs are already applied; queue the expectation, compare, then clock.
    task automatic cyc(input bit chk_en);
        logic [8:0]  c;
        bit          nk, acc;
        logic [31:0] np;
        exp_t        e;
        model_eval(c, nk, np, acc);
        exp_q.push_back({c, (m_fkill ? m_pend : redirect_target_i), m_sc, m_fc});
        #1;
        e = exp_q.pop_front();
        if (chk_en) begin
            check("ctrl", {23'd0, imem_read_o, pc_load_o, pc_sel_o, if_id_load_o, if_id_flush_o,
                           id_ex_load_o, id_ex_flush_o, ex_mem_load_o, mem_wb_load_o},
                  {23'd0, e.ctrl});
            check("pc_target", pc_target_o, e.tgt);
            check("stall_cnt", stall_cnt_o, e.sc);
            check("flush_cnt", {16'd0, flush_cnt_o}, {16'd0, e.fc});
        end
        @(posedge clk);
        if (rst) begin
            m_fkill = 1'b0; m_pend = 32'd0; m_sc = 32'd0; m_fc = 16'd0;
        end else begin
            m_fkill = nk;
            m_pend  = np;
            if (!c[7] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            if (acc && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        imem_resp_i = 1'b1; dmem_req_i = 1'b0; dmem_resp_i = 1'b0;
        ex_redirect_i = 1'b0; redirect_target_i = 32'h0000_0000;
        ex_memread_i = 1'b0; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    endtask

    logic [31:0] sc0;
    logic [15:0] fc0;

    initial begin
        idle_inputs();
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        #1;
        check("rst_imem_read", {31'd0, imem_read_o}, 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        rst = 1'b0;

        // Free-running fetch, no hazards
        for (int i = 0; i < 10; i++) cyc(1'b1);
        check("no_stall", stall_cnt_o, 32'd0);

        // Load-use on rs2, then the x0 destination variant
        ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd1; id_rs2_i = 5'd5;
        #1;
        check("lu_pc_load", {31'd0, pc_load_o}, 32'd0);
        check("lu_id_ex_flush", {31'd0, id_ex_flush_o}, 32'd1);
        cyc(1'b1);
        ex_rd_i = 5'd0; id_rs2_i = 5'd0;
        #1;
        check("lu_x0_pc_load", {31'd0, pc_load_o}, 32'd1);
        cyc(1'b1);
        idle_inputs();

        // Redirect while the fetch is outstanding -> FKILL, resolved 3 cycles later
        ex_redirect_i = 1'b1; redirect_target_i = 32'h4000_0100; imem_resp_i = 1'b0;
        cyc(1'b1);
        ex_redirect_i = 1'b0; redirect_target_i = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fkill_if_id_flush", {31'd0, if_id_flush_o}, 32'd1);
            cyc(1'b1);
        end
        imem_resp_i = 1'b1;
        #1;
        check("fkill_pc_sel", {31'd0, pc_sel_o}, 32'd1);
        check("fkill_target", pc_target_o, 32'h4000_0100);
        cyc(1'b1);
        check("flush_cnt_one", {16'd0, flush_cnt_o}, 32'd1);

        // Back-end stall hides a redirect for 4 cycles
        sc0 = stall_cnt_o; fc0 = flush_cnt_o;
        dmem_req_i = 1'b1; dmem_resp_i = 1'b0;
        ex_redirect_i = 1'b1; redirect_target_i = 32'h0000_2000;
        for (int i = 0; i < 4; i++) cyc(1'b1);
        check("bs_stall_delta", stall_cnt_o, sc0 + 32'd4);
        check("bs_flush_held", {16'd0, flush_cnt_o}, {16'd0, fc0});
        dmem_resp_i = 1'b1;
        cyc(1'b1);
        check("bs_redirect_acc", {16'd0, flush_cnt_o}, {16'd0, fc0 + 16'd1});
        idle_inputs();

        // Reset while a redirect is pending in FKILL
        ex_redirect_i = 1'b1; redirect_target_i = 32'h1234_5678; imem_resp_i = 1'b0;
        cyc(1'b1);
        ex_redirect_i = 1'b0; redirect_target_i = 32'h0000_0040;
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0; imem_resp_i = 1'b1;
        #1;
        check("rst_fkill_pc_sel", {31'd0, pc_sel_o}, 32'd0);
        check("rst_fkill_stall", stall_cnt_o, 32'd0);
        check("rst_fkill_flush", {16'd0, flush_cnt_o}, 32'd0);
        cyc(1'b1);

        // Randomised mix checked against the model
        for (int i = 0; i < 400; i++) begin
            rst               = ($urandom_range(0, 59) == 0);
            imem_resp_i       = ($urandom_range(0, 3) != 0);
            dmem_req_i        = ($urandom_range(0, 3) == 0);
            dmem_resp_i       = $urandom_range(0, 1) == 1;
            ex_redirect_i     = ($urandom_range(0, 4) == 0);
            redirect_target_i = $urandom;
            ex_memread_i      = $urandom_range(0, 1) == 1;
            ex_rd_i           = 5'($urandom_range(0, 3));
            id_rs1_i          = 5'($urandom_range(0, 3));
            id_rs2_i          = 5'($urandom_range(0, 3));
            cyc(1'b1);
        end
        idle_inputs();
        rst = 1'b0;

        // Flush counter saturation
        ex_redirect_i = 1'b1; redirect_target_i = 32'h0000_0800;
        for (int i = 0; i < 65540; i++) cyc(1'b0);
        check("flush_sat", {16'd0, flush_cnt_o}, 32'h0000_FFFF);
        cyc(1'b1);
        check("flush_sat_hold", {16'd0, flush_cnt_o}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
